// File: rtl/udp_rxbuf_reader.sv
// udp_rxbuf_reader: owns the 2**ADDR_W x 32 UDP RX buffer written by the core.
// While the CPU side holds the grant, it drains one datagram as a byte AXI-Stream
// and then pulses cpu_rel to hand the buffer back.
// Buffer layout: word0[15:0] = byte length; payload is little-endian from word1.

module udp_rxbuf_reader #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned MAX_BYTES = 252
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ce,
    input  logic              wr_we,
    input  logic [31:0]       wr_data,
    input  logic              cpu_grant,
    output logic              cpu_rel,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [15:0]       pkt_count,
    output logic              wr_viol
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StHdr    = 3'd1;
    localparam logic [2:0] StLoad   = 3'd2;
    localparam logic [2:0] StStream = 3'd3;
    localparam logic [2:0] StRel    = 3'd4;
    localparam logic [2:0] StWait   = 3'd5;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       rd_data_q;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_m1_q, len_m1_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [31:0]       shreg_q, shreg_d;
    logic              tvalid_q, tvalid_d;
    logic [15:0]       pkt_count_q, pkt_count_d;
    logic              wr_viol_q;

    logic [15:0]       hdr_len;
    logic [15:0]       hdr_clamped;
    logic              handshake;
    logic              last_byte;

    assign wr_en       = wr_ce & wr_we & ~cpu_grant;
    assign hdr_len     = rd_data_q[15:0];
    assign hdr_clamped = (hdr_len > MAX_LEN) ? MAX_LEN : hdr_len;
    assign handshake   = tvalid_q & m_axis_tready;
    assign last_byte   = (cnt_q == len_m1_q);

    // Buffer RAM: core write port, registered read port (contents not reset).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    // Next-state logic for the drain sequencer.
    always_comb begin
        state_d     = state_q;
        len_m1_d    = len_m1_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        shreg_d     = shreg_q;
        tvalid_d    = tvalid_q;
        pkt_count_d = pkt_count_q;
        rd_en       = 1'b0;
        rd_addr     = '0;

        case (state_q)
            StIdle: begin
                if (cpu_grant) begin
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (!cpu_grant) begin
                    state_d = StIdle;
                end else begin
                    len_m1_d = 8'(hdr_clamped - 16'd1);
                    cnt_d    = 8'd0;
                    rd_en    = 1'b1;
                    rd_addr  = ADDR_W'(1);
                    word_d   = ADDR_W'(2);
                    state_d  = (hdr_clamped == 16'd0) ? StRel : StLoad;
                end
            end
            StLoad: begin
                if (!cpu_grant) begin
                    state_d = StIdle;
                end else begin
                    shreg_d  = rd_data_q;
                    // Prefetch the following word so the stream has no gaps.
                    rd_en    = 1'b1;
                    rd_addr  = word_q;
                    word_d   = word_q + ADDR_W'(1);
                    tvalid_d = 1'b1;
                    state_d  = StStream;
                end
            end
            StStream: begin
                if (!cpu_grant) begin
                    // Arbiter fault: abandon the datagram without release.
                    tvalid_d = 1'b0;
                    state_d  = StIdle;
                end else if (handshake) begin
                    if (last_byte) begin
                        tvalid_d    = 1'b0;
                        pkt_count_d = pkt_count_q + 16'd1;
                        state_d     = StRel;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q[1:0] == 2'd3) begin
                            shreg_d = rd_data_q;
                            rd_en   = 1'b1;
                            rd_addr = word_q;
                            word_d  = word_q + ADDR_W'(1);
                        end else begin
                            shreg_d = {8'h00, shreg_q[31:8]};
                        end
                    end
                end
            end
            StRel: begin
                state_d = StWait;
            end
            StWait: begin
                // Grant is still registered high right after release.
                if (!cpu_grant) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer and stream registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            len_m1_q    <= 8'd0;
            cnt_q       <= 8'd0;
            word_q      <= '0;
            shreg_q     <= 32'd0;
            tvalid_q    <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            len_m1_q    <= len_m1_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            shreg_q     <= shreg_d;
            tvalid_q    <= tvalid_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Sticky flag for core writes attempted while the CPU owns the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_viol_q <= 1'b0;
        end else if (wr_ce && wr_we && cpu_grant) begin
            wr_viol_q <= 1'b1;
        end
    end

    assign cpu_rel       = (state_q == StRel);
    assign m_axis_tdata  = shreg_q[7:0];
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tvalid_q & last_byte;
    assign pkt_count     = pkt_count_q;
    assign wr_viol       = wr_viol_q;

endmodule

// File: tb/tb_udp_rxbuf_reader.sv
// Bench for udp_rxbuf_reader: directed datagrams plus randomized ones, checked
// every cycle against a timeline model of the drain (grant cycle + 3 to first
// byte, one byte per accepted beat, release the cycle after the last byte).

module tb_udp_rxbuf_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  wr_addr;
    logic        wr_ce;
    logic        wr_we;
    logic [31:0] wr_data;
    logic        cpu_grant;
    logic        cpu_rel;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [15:0] pkt_count;
    logic        wr_viol;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state.
    int          cyc;
    bit          m_active, m_waiting, m_viol;
    int          m_g, m_len, m_sent, m_rel_cyc;
    logic [15:0] m_pkt;
    logic [31:0] mem_m [64];
    logic [31:0] snap  [64];
    int          hs_cnt = 0;
    int          last_cnt = 0;

    udp_rxbuf_reader #(.ADDR_W(6), .MAX_BYTES(252)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_addr      (wr_addr),
        .wr_ce        (wr_ce),
        .wr_we        (wr_we),
        .wr_data      (wr_data),
        .cpu_grant    (cpu_grant),
        .cpu_rel      (cpu_rel),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .pkt_count    (pkt_count),
        .wr_viol      (wr_viol)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] sbyte(input int k);
        logic [31:0] w;
        w = snap[1 + k / 4];
        return w[8 * (k % 4) +: 8];
    endfunction

    // Per-cycle compare against the model, then advance the model.
    initial begin
        bit          ev, el;
        logic [31:0] hdr;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_active = 0; m_waiting = 0; m_viol = 0; m_pkt = 16'd0; m_rel_cyc = -1;
            end else begin
                ev = m_active && (cyc >= m_g + 3) && (m_sent < m_len);
                el = ev && (m_sent == m_len - 1);
                chk("tvalid", 32'(m_axis_tvalid), 32'(ev));
                chk("tlast", 32'(m_axis_tlast), 32'(el));
                if (ev) chk("tdata", 32'(m_axis_tdata), 32'(sbyte(m_sent)));
                chk("cpu_rel", 32'(cpu_rel), 32'(cyc == m_rel_cyc));
                chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
                chk("wr_viol", 32'(wr_viol), 32'(m_viol));
                if (m_axis_tvalid && m_axis_tready) begin
                    hs_cnt++;
                    if (m_axis_tlast) last_cnt++;
                end
                if (m_active) begin
                    if (cyc >= m_g + 1 && !cpu_grant) begin
                        m_active = 0;
                    end else if (m_len == 0) begin
                        if (cyc == m_g + 1) begin
                            m_active = 0; m_waiting = 1; m_rel_cyc = cyc + 1;
                        end
                    end else if (ev && m_axis_tready) begin
                        if (el) begin
                            m_active = 0; m_waiting = 1; m_rel_cyc = cyc + 1; m_pkt++;
                        end
                        m_sent++;
                    end
                end else if (m_waiting) begin
                    if (cyc > m_rel_cyc && !cpu_grant) m_waiting = 0;
                end else if (cpu_grant) begin
                    m_active = 1; m_g = cyc; m_sent = 0; snap = mem_m;
                    hdr = mem_m[0];
                    m_len = (hdr[15:0] > 16'd252) ? 252 : int'(hdr[15:0]);
                end
                if (wr_ce && wr_we) begin
                    if (cpu_grant) m_viol = 1;
                    else mem_m[wr_addr] = wr_data;
                end
            end
            cyc++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [31:0] d, input bit we);
        wr_addr = 6'(a); wr_data = d; wr_ce = 1'b1; wr_we = we;
        tick();
        wr_ce = 1'b0; wr_we = 1'b0;
    endtask

    // Grant the buffer and wait for the model to finish (or abort at abort_at).
    task automatic run_pkt(input int rmode, input int abort_at, input bit viol_wr);
        bit done = 0;
        cpu_grant = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            case (rmode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (k % 3 == 0);
                default: m_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
            if (viol_wr && k == 1) begin
                wr_addr = 6'd1; wr_data = $urandom; wr_ce = 1'b1; wr_we = 1'b1;
            end else begin
                wr_ce = 1'b0; wr_we = 1'b0;
            end
            if (abort_at != 0 && k == abort_at) begin
                cpu_grant = 1'b0;
                done = 1;
                break;
            end
            tick();
            if (k >= 1 && !m_active) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", 32'(done), 32'd1);
        wr_ce = 1'b0; wr_we = 1'b0;
        cpu_grant = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [7:0] t1_exp [5];
        int h0, l0;
        bit seen;
        t1_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        reset_n = 1'b0; wr_addr = '0; wr_ce = 1'b0; wr_we = 1'b0; wr_data = '0;
        cpu_grant = 1'b0; m_axis_tready = 1'b0;
        repeat (3) tick();
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_rel", 32'(cpu_rel), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        chk("rst_viol", 32'(wr_viol), 32'd0);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) write_word(i, $urandom, 1'b1);

        // Test 1: five bytes, fixed timing.
        write_word(0, 32'd5, 1'b1);
        write_word(1, 32'h4433_2211, 1'b1);
        write_word(2, 32'h0000_0055, 1'b1);
        cpu_grant = 1'b1; m_axis_tready = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i >= 3 && i <= 7) begin
                chk("t1_tvalid", 32'(m_axis_tvalid), 32'd1);
                chk("t1_tdata", 32'(m_axis_tdata), 32'(t1_exp[i - 3]));
                chk("t1_tlast", 32'(m_axis_tlast), 32'(i == 7));
            end else begin
                chk("t1_tvalid_off", 32'(m_axis_tvalid), 32'd0);
            end
            chk("t1_rel", 32'(cpu_rel), 32'(i == 8));
        end
        chk("t1_pkt", 32'(pkt_count), 32'd1);
        tick();
        cpu_grant = 1'b0;
        repeat (3) tick();

        // Test 2: zero-length datagram, grant held afterwards.
        write_word(0, 32'hABCD_0000, 1'b1);
        cpu_grant = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t2_rel_n1", 32'(cpu_rel), 32'd0);
        @(negedge clk);
        chk("t2_rel_n2", 32'(cpu_rel), 32'd1);
        chk("t2_tvalid", 32'(m_axis_tvalid), 32'd0);
        repeat (6) tick();
        cpu_grant = 1'b0;
        repeat (3) tick();
        chk("t2_pkt", 32'(pkt_count), 32'd1);

        // Test 3: eight bytes with tready pattern 1,0,0,1,...
        write_word(0, 32'd8, 1'b1);
        write_word(1, $urandom, 1'b1);
        write_word(2, $urandom, 1'b1);
        h0 = hs_cnt; l0 = last_cnt;
        run_pkt(1, 0, 1'b0);
        chk("t3_bytes", 32'(hs_cnt - h0), 32'd8);
        chk("t3_tlasts", 32'(last_cnt - l0), 32'd1);
        chk("t3_pkt", 32'(pkt_count), 32'd2);

        // Test 4: length 1024 clamps to 252.
        write_word(0, 32'h0000_0400, 1'b1);
        h0 = hs_cnt; l0 = last_cnt;
        run_pkt(0, 0, 1'b0);
        chk("t4_bytes", 32'(hs_cnt - h0), 32'd252);
        chk("t4_tlasts", 32'(last_cnt - l0), 32'd1);
        chk("t4_pkt", 32'(pkt_count), 32'd3);

        // Test 5: write while granted is dropped and flagged.
        write_word(0, 32'd4, 1'b1);
        write_word(1, 32'hA1B2_C3D4, 1'b1);
        run_pkt(2, 0, 1'b1);
        chk("t5_viol", 32'(wr_viol), 32'd1);
        run_pkt(0, 0, 1'b0);
        chk("t5_viol_sticky", 32'(wr_viol), 32'd1);
        chk("t5_pkt", 32'(pkt_count), 32'd5);

        // Test 6a: grant dropped after three bytes.
        write_word(0, 32'd40, 1'b1);
        cpu_grant = 1'b1; m_axis_tready = 1'b1;
        h0 = hs_cnt; seen = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (hs_cnt - h0 >= 3) begin
                seen = 1;
                break;
            end
        end
        chk("t6_reach3", 32'(seen), 32'd1);
        cpu_grant = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_tvalid_drop", 32'(m_axis_tvalid), 32'd0);
        chk("t6_no_rel", 32'(cpu_rel), 32'd0);
        repeat (4) tick();
        chk("t6_pkt", 32'(pkt_count), 32'd5);

        // Test 6b: asynchronous reset mid-stream.
        cpu_grant = 1'b1;
        h0 = hs_cnt; seen = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (hs_cnt - h0 >= 2) begin
                seen = 1;
                break;
            end
        end
        chk("t6_reach2", 32'(seen), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t6_rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("t6_rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("t6_rst_rel", 32'(cpu_rel), 32'd0);
        chk("t6_rst_pkt", 32'(pkt_count), 32'd0);
        chk("t6_rst_viol", 32'(wr_viol), 32'd0);
        cpu_grant = 1'b0; m_axis_tready = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        write_word(0, 32'd3, 1'b1);
        run_pkt(0, 0, 1'b0);
        chk("t6_recover_pkt", 32'(pkt_count), 32'd1);

        // Randomized datagrams.
        for (int p = 0; p < 25; p++) begin
            int sel, len, nw, ab;
            sel = $urandom_range(0, 9);
            if (sel < 4) len = $urandom_range(0, 12);
            else if (sel < 8) len = $urandom_range(13, 260);
            else len = $urandom_range(0, 65535);
            write_word(0, {16'($urandom), 16'(len)}, 1'b1);
            nw = ((len > 252) ? 252 : len + 3) / 4;
            for (int i = 1; i <= nw; i++) write_word(i, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) write_word(1, $urandom, 1'b0);
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 40) : 0;
            run_pkt(2, ab, $urandom_range(0, 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
